i2c_reg_slave: RTL and testbench

//  I2C target (responder) exposing lag-tester results and config to an external host/MCU.

---
 rtl/i2c_reg_slave.sv | 214 +++++++++++++++++++++
 tb/tb_i2c_reg_slave.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_slave.sv
// I2C target exposing the latched lag result, live status and a config register.
// The bus is oversampled on "clock"; SCL is never stretched.
module i2c_reg_slave #(
    parameter logic [6:0] DEV_ADDR    = 7'h2C,
    parameter int         FILTER_LEN  = 4,
    parameter int         HOLD_CYCLES = 8,
    parameter logic [7:0] CONFIG_RST  = 8'h00
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [19:0] bcd_result,
    input  logic [7:0]  status,
    output logic [7:0]  config_out,
    output logic        config_wr,
    output logic        busy
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
    } state_t;

    state_t state, state_nx;

    // Index 1 carries SCL, index 0 carries SDA through sync, filter and edge history.
    logic [1:0]    meta, sync, filt, filt_d;
    logic [FW-1:0] fcnt [2];

    logic scl_rise, scl_fall, start_det, stop_det;

    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [7:0]    tx_byte;
    logic [2:0]    pointer;
    logic          rw;
    logic          first_byte;
    logic          master_ack;
    logic [19:0]   shadow;
    logic [7:0]    scratch;
    logic          cfg_upd;
    logic [HW-1:0] hold_cnt;

    logic          addr_match;
    logic          sda_drive;
    logic [7:0]    rd_mux;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta    <= 2'b11;
            sync    <= 2'b11;
            filt    <= 2'b11;
            filt_d  <= 2'b11;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            meta   <= {scl_in, sda_in};
            sync   <= meta;
            filt_d <= filt;
            // A new level must persist FILTER_LEN consecutive clocks before it is accepted.
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
                    filt[i] <= sync[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign scl_rise  =  filt[1] & ~filt_d[1];
    assign scl_fall  = ~filt[1] &  filt_d[1];
    assign start_det =  filt[1] &  filt_d[1] &  filt_d[0] & ~filt[0];
    assign stop_det  =  filt[1] &  filt_d[1] & ~filt_d[0] &  filt[0];

    assign addr_match = (shreg[7:1] == DEV_ADDR);

    always_comb begin
        rd_mux = 8'hA5;
        case (pointer)
            3'd0: rd_mux = {4'h0, shadow[19:16]};
            3'd1: rd_mux = shadow[15:8];
            3'd2: rd_mux = shadow[7:0];
            3'd3: rd_mux = status;
            3'd4: rd_mux = config_out;
            3'd5: rd_mux = scratch;
            3'd6: rd_mux = {1'b0, DEV_ADDR};
            default: rd_mux = 8'hA5;
        endcase
    end

    always_comb begin
        sda_drive = 1'b0;
        case (state)
            ADDR_ACK, WR_ACK: sda_drive = 1'b1;
            RD_BYTE:          sda_drive = ~tx_byte[~bit_cnt[2:0]];
            default:          sda_drive = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (start_det) begin
            state_nx = ADDR;
        end else if (stop_det) begin
            state_nx = IDLE;
        end else if (scl_fall) begin
            case (state)
                ADDR:     if (bit_cnt == 4'd8) state_nx = addr_match ? ADDR_ACK : IGNORE;
                ADDR_ACK: state_nx = rw ? RD_BYTE : WR_BYTE;
                WR_BYTE:  if (bit_cnt == 4'd8) state_nx = WR_ACK;
                WR_ACK:   state_nx = WR_BYTE;
                RD_BYTE:  if (bit_cnt == 4'd8) state_nx = RD_ACK;
                RD_ACK:   state_nx = master_ack ? RD_BYTE : IGNORE;
                default:  state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            tx_byte    <= '0;
            pointer    <= '0;
            rw         <= 1'b0;
            first_byte <= 1'b0;
            master_ack <= 1'b0;
            shadow     <= '0;
            scratch    <= '0;
            config_out <= CONFIG_RST;
            cfg_upd    <= 1'b0;
            config_wr  <= 1'b0;
            hold_cnt   <= '0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cfg_upd   <= 1'b0;
            config_wr <= cfg_upd;
            if (start_det || stop_det) begin
                // Any partially shifted byte is dropped; the pointer keeps its value.
                bit_cnt  <= '0;
                hold_cnt <= '0;
                sda_oe   <= 1'b0;
                busy     <= start_det;
            end else begin
                if (scl_rise) begin
                    case (state)
                        ADDR, WR_BYTE, RD_BYTE: begin
                            shreg   <= {shreg[6:0], filt[0]};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                        RD_ACK: master_ack <= ~filt[0];
                        WR_ACK: begin
                            if (first_byte) begin
                                pointer    <= shreg[2:0];
                                first_byte <= 1'b0;
                            end else begin
                                if (pointer == 3'd4) begin
                                    config_out <= shreg;
                                    cfg_upd    <= 1'b1;
                                end else if (pointer == 3'd5) begin
                                    scratch <= shreg;
                                end
                                pointer <= pointer + 3'd1;
                            end
                        end
                        default: ;
                    endcase
                end
                if (scl_fall) begin
                    hold_cnt <= HW'(HOLD_CYCLES - 1);
                    case (state)
                        ADDR: if (bit_cnt == 4'd8) begin
                            bit_cnt <= '0;
                            rw      <= shreg[0];
                            if (addr_match && shreg[0]) shadow <= bcd_result;
                        end
                        ADDR_ACK: begin
                            first_byte <= 1'b1;
                            if (rw) begin
                                tx_byte <= rd_mux;
                                pointer <= pointer + 3'd1;
                            end
                        end
                        WR_BYTE, RD_BYTE: if (bit_cnt == 4'd8) bit_cnt <= '0;
                        RD_ACK: if (master_ack) begin
                            tx_byte <= rd_mux;
                            pointer <= pointer + 3'd1;
                        end
                        default: ;
                    endcase
                end else if (hold_cnt != '0) begin
                    // SDA moves only once the data hold time after SCL fell has elapsed.
                    hold_cnt <= hold_cnt - 1'b1;
                    if (hold_cnt == HW'(1)) sda_oe <= sda_drive;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: bit-banged I2C master on an open-drain SDA model,
// table-driven register write/readback plus hand-written corner sequences.
module tb_i2c_reg_slave;

    localparam int         Q          = 18;
    localparam logic [6:0] DEV        = 7'h2C;
    localparam int         FILTER_LEN = 4;
    localparam int         HOLD       = 8;
    localparam logic [7:0] CFG_RST    = 8'h00;
    localparam logic [7:0] STATUS_V   = 8'h5B;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        scl_in, sda_in;
    logic        sda_oe;
    logic [19:0] bcd_result = 20'h12345;
    logic [7:0]  status = STATUS_V;
    logic [7:0]  config_out;
    logic        config_wr;
    logic        busy;

    assign scl_in = scl_m;
    assign sda_in = sda_m & ~sda_oe;

    always #5 clock = ~clock;

    i2c_reg_slave #(
        .DEV_ADDR(DEV), .FILTER_LEN(FILTER_LEN), .HOLD_CYCLES(HOLD), .CONFIG_RST(CFG_RST)
    ) dut (
        .clock(clock), .reset_n(reset_n), .scl_in(scl_in), .sda_in(sda_in),
        .sda_oe(sda_oe), .bcd_result(bcd_result), .status(status),
        .config_out(config_out), .config_wr(config_wr), .busy(busy)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         lat;
    logic [7:0] m_cfg = CFG_RST;
    logic [7:0] m_scratch = 8'h00;

    int         wr_pulses = 0;
    logic [7:0] cfg_prev, cfg_at_pulse, cfg_before_pulse;
    logic       watch = 1'b0;
    logic       oe_seen, busy_low_seen, busy_high_seen;

    always @(negedge clock) begin
        if (config_wr) begin
            wr_pulses++;
            cfg_at_pulse = config_out;
            cfg_before_pulse = cfg_prev;
        end
        cfg_prev = config_out;
        if (watch && sda_oe) oe_seen = 1'b1;
        if (watch && !busy)  busy_low_seen = 1'b1;
        if (watch && busy)   busy_high_seen = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_rd(input logic [2:0] p, input logic [19:0] b);
        case (p)
            3'd0: model_rd = {4'h0, b[19:16]};
            3'd1: model_rd = b[15:8];
            3'd2: model_rd = b[7:0];
            3'd3: model_rd = STATUS_V;
            3'd4: model_rd = m_cfg;
            3'd5: model_rd = m_scratch;
            3'd6: model_rd = {1'b0, DEV};
            default: model_rd = 8'hA5;
        endcase
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b1; wait_clks(Q);
    endtask

    // One SCL period; returns the sampled SDA and records clocks from SCL fall to an sda_oe change.
    task automatic send_bit(input logic b, output logic s);
        logic oe0;
        sda_m = b;    wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        s = sda_in;   wait_clks(Q);
        oe0 = sda_oe;
        scl_m = 1'b0;
        lat = -1;
        for (int n = 1; n <= Q; n++) begin
            @(negedge clock);
            if (lat < 0 && sda_oe != oe0) lat = n;
        end
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack_n);
        logic s;
        for (int i = 7; i >= 0; i--) send_bit(d[i], s);
        send_bit(1'b1, ack_n);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, s);
            d[i] = s;
        end
        send_bit(nack, s);
    endtask

    task automatic wr_reg(input logic [2:0] ptr, input logic [7:0] data, input string tag);
        logic a;
        i2c_start();
        write_byte({DEV, 1'b0}, a);  check({tag, "_addr_ack"}, a, 0);
        write_byte({5'h0, ptr}, a);  check({tag, "_ptr_ack"}, a, 0);
        write_byte(data, a);         check({tag, "_data_ack"}, a, 0);
        i2c_stop();
        if (ptr == 3'd4) m_cfg = data;
        if (ptr == 3'd5) m_scratch = data;
    endtask

    logic bcd_flip = 1'b0;

    task automatic rd_regs(input logic [2:0] ptr, input int n, input logic set_ptr, input string tag);
        logic       a;
        logic [7:0] d, e;
        if (set_ptr) begin
            i2c_start();
            write_byte({DEV, 1'b0}, a); check({tag, "_waddr_ack"}, a, 0);
            write_byte({5'h0, ptr}, a); check({tag, "_ptr_ack"}, a, 0);
        end
        i2c_start();
        write_byte({DEV, 1'b1}, a);     check({tag, "_raddr_ack"}, a, 0);
        if (bcd_flip) bcd_result = 20'h99999;
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d);
            if (exp_q.size() == 0) begin
                check({tag, "_queue_empty"}, 1, 0);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_rd_data"}, d, e);
            end
        end
        i2c_stop();
    endtask

    typedef struct {
        logic [2:0] ptr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        int         exp_pulses;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic       a, s;
        logic [7:0] d;

        vecs[0] = '{3'd1, 8'h77, 8'h23, 0};
        vecs[1] = '{3'd3, 8'h00, STATUS_V, 0};
        vecs[2] = '{3'd5, 8'hC3, 8'hC3, 0};
        vecs[3] = '{3'd6, 8'h11, 8'h2C, 0};
        vecs[4] = '{3'd4, 8'h96, 8'h96, 1};
        vecs[5] = '{3'd0, 8'hFF, 8'h01, 0};

        // Reset state
        wait_clks(4);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_config_out", config_out, CFG_RST);
        check("rst_config_wr", config_wr, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        wait_clks(10);

        // Write config register
        wr_pulses = 0;
        wr_reg(3'd4, 8'h5A, "t1");
        wait_clks(4);
        check("t1_config_out", config_out, 8'h5A);
        check("t1_wr_pulses", wr_pulses, 1);
        check("t1_cfg_before_pulse", cfg_before_pulse, 8'h5A);
        check("t1_busy_after_stop", busy, 0);

        // Multi-byte read from a coherent snapshot
        for (int p = 0; p < 3; p++) exp_q.push_back(model_rd(3'(p), 20'h12345));
        bcd_flip = 1'b1;
        rd_regs(3'd0, 3, 1'b1, "t2");
        bcd_flip = 1'b0;
        bcd_result = 20'h12345;
        check("t2_oe_released", sda_oe, 0);

        // Wrong address
        oe_seen = 1'b0;
        watch = 1'b1;
        i2c_start();
        check("t3_busy_on_start", busy, 1);
        write_byte({7'h2D, 1'b0}, a); check("t3_addr_nack", a, 1);
        write_byte(8'h04, a);         check("t3_ptr_nack", a, 1);
        write_byte(8'h33, a);         check("t3_data_nack", a, 1);
        watch = 1'b0;
        i2c_stop();
        check("t3_oe_never", oe_seen, 0);
        check("t3_config_kept", config_out, m_cfg);
        check("t3_busy_cleared", busy, 0);

        // Pointer wrap 7 -> 0
        exp_q.push_back(8'hA5);
        exp_q.push_back(model_rd(3'd0, bcd_result));
        rd_regs(3'd7, 2, 1'b1, "t4");

        // Register table: write then read back
        for (int i = 0; i < 6; i++) begin
            wr_pulses = 0;
            wr_reg(vecs[i].ptr, vecs[i].wdata, $sformatf("vec%0d", i));
            exp_q.push_back(vecs[i].exp_rd);
            rd_regs(vecs[i].ptr, 1, 1'b1, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_wr_pulses", i), wr_pulses, vecs[i].exp_pulses);
            check($sformatf("vec%0d_config", i), config_out, m_cfg);
        end

        // STOP after 4 data bits: byte discarded, pointer still 5
        i2c_start();
        write_byte({DEV, 1'b0}, a);   check("t5_addr_ack", a, 0);
        write_byte(8'h05, a);         check("t5_ptr_ack", a, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, s);
        i2c_stop();
        exp_q.push_back(m_scratch);
        rd_regs(3'd0, 1, 1'b0, "t5_abort");

        // Reset while the target drives a read bit
        i2c_start();
        write_byte({DEV, 1'b0}, a);   check("t5r_addr_ack", a, 0);
        write_byte(8'h07, a);         check("t5r_ptr_ack", a, 0);
        i2c_start();
        write_byte({DEV, 1'b1}, a);   check("t5r_raddr_ack", a, 0);
        send_bit(1'b1, s);
        check("t5r_bit7", s, 1);
        check("t5r_hold_latency", (lat >= HOLD + FILTER_LEN && lat <= HOLD + FILTER_LEN + 3), 1);
        check("t5r_oe_driving", sda_oe, 1);
        reset_n = 1'b0;
        #1;
        check("t5r_oe_async_release", sda_oe, 0);
        wait_clks(2);
        check("t5r_config_rst", config_out, CFG_RST);
        check("t5r_busy_rst", busy, 0);
        reset_n = 1'b1;
        m_cfg = CFG_RST;
        m_scratch = 8'h00;
        wait_clks(4);
        i2c_stop();
        exp_q.push_back(model_rd(3'd0, bcd_result));
        rd_regs(3'd0, 1, 1'b0, "t5r_ptr_zero");

        // Short SDA glitch while idle: no START
        busy_high_seen = 1'b0;
        watch = 1'b1;
        sda_m = 1'b0; wait_clks(FILTER_LEN - 1);
        sda_m = 1'b1; wait_clks(20);
        watch = 1'b0;
        check("t6_idle_glitch_no_start", busy_high_seen, 0);

        // Longer SDA pulse while idle is a real START then STOP
        busy_high_seen = 1'b0;
        watch = 1'b1;
        sda_m = 1'b0; wait_clks(FILTER_LEN + 2);
        sda_m = 1'b1; wait_clks(20);
        watch = 1'b0;
        check("t6_long_pulse_start", busy_high_seen, 1);
        check("t6_long_pulse_stop", busy, 0);

        // High glitch on SDA during a data bit: no STOP, byte still written
        i2c_start();
        write_byte({DEV, 1'b0}, a);   check("t6_addr_ack", a, 0);
        write_byte(8'h05, a);         check("t6_ptr_ack", a, 0);
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q / 2);
        busy_low_seen = 1'b0;
        watch = 1'b1;
        sda_m = 1'b1; wait_clks(FILTER_LEN - 1);
        sda_m = 1'b0; wait_clks(Q / 2);
        watch = 1'b0;
        scl_m = 1'b0; wait_clks(Q);
        d = 8'h3C;
        for (int i = 6; i >= 0; i--) send_bit(d[i], s);
        send_bit(1'b1, a);
        check("t6_data_ack", a, 0);
        check("t6_no_stop", busy_low_seen, 0);
        i2c_stop();
        m_scratch = 8'h3C;
        exp_q.push_back(model_rd(3'd5, bcd_result));
        rd_regs(3'd5, 1, 1'b1, "t6_readback");

        check("final_queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
